// File: rtl/dot_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dot_pkg: shared sizes, types and the result-width helper for the feeder.
// Rev 1.0
// ----------------------------------------------------------------------------
package dot_pkg;

  function automatic int calc_out_w(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

  localparam int WIDTH     = 8;
  localparam int N         = 3;
  localparam int FRAME     = 2 * N;
  localparam int OUT_W     = calc_out_w(WIDTH, N);
  localparam int RES_DEPTH = 2;

  typedef logic [$clog2(FRAME)-1:0] phase_t;
  typedef logic [WIDTH-1:0]         elem_t;

endpackage
`default_nettype wire

// File: rtl/dot_result_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dot_result_fifo: small shift-style FIFO whose head is a flop, so rd_data is
// registered. Rev 1.0
// ----------------------------------------------------------------------------
module dot_result_fifo
  import dot_pkg::*;
#(
  parameter int DEPTH = RES_DEPTH,
  parameter int W     = OUT_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [W-1:0]                 rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  slot    [DEPTH];
  logic [W-1:0]  shifted [DEPTH];
  logic          pop;
  logic [CW-1:0] wr_idx;

  assign rd_valid = (count != '0);
  assign rd_data  = slot[0];
  assign pop      = rd_valid & rd_ready;
  // A simultaneous pop moves everything down one slot, so the write lands lower.
  assign wr_idx   = pop ? (count - CW'(1)) : count;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    if (i < DEPTH - 1) begin : g_mid
      assign shifted[i] = slot[i+1];
    end else begin : g_last
      assign shifted[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) slot[i] <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx == CW'(i))) slot[i] <= push_data;
        else if (pop)                   slot[i] <= shifted[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dot_stream_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dot_stream_feeder: frames A/B vectors onto the dot unit's byte stream and
// collects its results into a small FIFO. Rev 1.0
// ----------------------------------------------------------------------------
module dot_stream_feeder
  import dot_pkg::*;
#(
  parameter int WIDTH     = dot_pkg::WIDTH,
  parameter int N         = dot_pkg::N,
  parameter int OUT_W     = calc_out_w(WIDTH, N),
  parameter int RES_DEPTH = dot_pkg::RES_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [N*WIDTH-1:0]   req_a,
  input  logic [N*WIDTH-1:0]   req_b,
  output logic [WIDTH-1:0]     din,
  input  logic                 run,
  input  logic [OUT_W-1:0]     dout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_W-1:0]     res_data,
  output logic                 err
);

  localparam int FRAME = 2 * N;
  localparam int PW    = $clog2(FRAME);
  localparam int CW    = $clog2(RES_DEPTH + 1);
  localparam int OW    = CW + 1;

  logic [PW-1:0]          p;
  logic [FRAME*WIDTH-1:0] shreg;
  logic [CW-1:0]          inflight;
  logic [CW-1:0]          fifo_count;
  logic                   streaming;
  logic                   cap_due;
  logic                   last_phase;
  logic                   first_phase;
  logic                   pop;
  logic                   accept;
  logic                   capture;
  logic                   push;
  logic [OW-1:0]          occupancy;

  assign last_phase  = (p == PW'(FRAME - 1));
  assign first_phase = (p == '0);
  assign pop         = res_valid & res_ready;
  assign occupancy   = OW'(fifo_count) + OW'(inflight) - OW'(pop);
  assign req_ready   = !reset && last_phase && (occupancy < OW'(RES_DEPTH));
  assign accept      = req_valid & req_ready;
  assign capture     = first_phase & cap_due;
  assign push        = capture & run;

  always_ff @(posedge clk) begin
    if (reset) begin
      p         <= '0;
      shreg     <= '0;
      din       <= '0;
      inflight  <= '0;
      streaming <= 1'b0;
      cap_due   <= 1'b0;
      err       <= 1'b0;
    end else begin
      p <= last_phase ? '0 : p + PW'(1);

      // a0 goes straight to din; the rest queue behind it, zero-filled at the top.
      if (accept) begin
        din   <= req_a[WIDTH-1:0];
        shreg <= {{WIDTH{1'b0}}, req_b, req_a[N*WIDTH-1:WIDTH]};
      end else begin
        din   <= shreg[WIDTH-1:0];
        shreg <= {{WIDTH{1'b0}}, shreg[FRAME*WIDTH-1:WIDTH]};
      end

      // streaming marks the frame now on din; cap_due marks the one just finished.
      if (last_phase) begin
        streaming <= accept;
        cap_due   <= streaming;
      end

      if (accept)       inflight <= inflight + CW'(1);
      else if (capture) inflight <= inflight - CW'(1);

      if ((capture && !run) || (run && !first_phase)) err <= 1'b1;
    end
  end

  dot_result_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (dout),
    .rd_ready  (res_ready),
    .rd_valid  (res_valid),
    .rd_data   (res_data),
    .count     (fifo_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_dot_stream_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dot_stream_feeder: random and directed traffic against a queue-based
// reference model and a behavioural dot-product unit. Rev 1.0
// ----------------------------------------------------------------------------
module tb_dot_stream_feeder;

  localparam int WIDTH = 8;
  localparam int N     = 3;
  localparam int OUT_W = 18;

  logic               clk;
  logic               reset;
  logic               req_valid;
  logic               req_ready;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]   din;
  logic               run;
  logic [OUT_W-1:0]   dout;
  logic               res_valid;
  logic               res_ready;
  logic [OUT_W-1:0]   res_data;
  logic               err;

  dot_stream_feeder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .din       (din),
    .run       (run),
    .dout      (dout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] dotv(input logic [23:0] a, input logic [23:0] b);
    logic [OUT_W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s += OUT_W'(a[8*i +: 8]) * OUT_W'(b[8*i +: 8]);
    return s;
  endfunction

  function automatic logic [23:0] vec(input int e0, input int e1, input int e2);
    return {8'(e2), 8'(e1), 8'(e0)};
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  typedef struct { int t; logic [23:0] a; logic [23:0] b; } req_t;
  req_t             pend[$];
  logic [OUT_W-1:0] exp_q[$];
  int               mph  = 0;
  int               mcyc = 0;
  bit               merr = 1'b0;
  bit               m_pop, m_rr;
  int               m_occ, m_k;
  logic [7:0]       m_din;

  always @(negedge clk) begin
    if (reset) begin
      pend.delete();
      exp_q.delete();
      mph  = 0;
      merr = 1'b0;
    end else begin
      m_pop = res_ready && (exp_q.size() > 0);
      m_occ = exp_q.size() + pend.size() - int'(m_pop);
      m_rr  = (mph == 5) && (m_occ < 2);
      m_din = 8'd0;
      foreach (pend[i]) begin
        if (mcyc > pend[i].t && mcyc <= pend[i].t + 6) begin
          m_k   = mcyc - pend[i].t - 1;
          m_din = (m_k < 3) ? pend[i].a[8*m_k +: 8] : pend[i].b[8*(m_k-3) +: 8];
        end
      end
      check("req_ready", req_ready, m_rr);
      check("din", din, m_din);
      check("res_valid", res_valid, exp_q.size() > 0);
      check("err", err, merr);
      if (exp_q.size() > 0) check("res_data", res_data, exp_q[0]);

      if (m_pop) void'(exp_q.pop_front());
      if (mph == 0 && pend.size() > 0 && pend[0].t + 7 == mcyc) begin
        if (run) exp_q.push_back(dotv(pend[0].a, pend[0].b));
        else     merr = 1'b1;
        void'(pend.pop_front());
      end
      if (run && mph != 0) merr = 1'b1;
      if (req_valid && m_rr) pend.push_back('{mcyc, req_a, req_b});
      mph = (mph + 1) % 6;
    end
    mcyc++;
  end

  // ---------------- stimulus + behavioural dot unit ----------------
  typedef struct { int c; logic [OUT_W-1:0] d; } res_t;
  res_t             got[$];
  int               uph = 0;
  int               gcyc = 0;
  int               suppress_at = -1;
  logic [7:0]       samp [6];
  logic [7:0]       din_log [8192];
  logic             err_log [8192];
  int               s_cyc;
  logic [7:0]       s_din;
  logic             s_rr, s_rv, s_err, s_acc;
  logic             nrun;
  logic [OUT_W-1:0] ndout;

  function automatic longint got_d(input int i);
    return (i < got.size()) ? longint'(got[i].d) : -1;
  endfunction

  function automatic longint got_c(input int i);
    return (i < got.size()) ? longint'(got[i].c) : -1000;
  endfunction

  task automatic tick();
    @(negedge clk);
    s_cyc = gcyc;
    s_din = din;
    s_rr  = req_ready;
    s_rv  = res_valid;
    s_err = err;
    s_acc = req_valid && req_ready;
    if (gcyc < 8192) begin
      din_log[gcyc] = din;
      err_log[gcyc] = err;
    end
    if (res_valid && res_ready) got.push_back('{gcyc, res_data});
    if (!reset) samp[uph] = din;
    @(posedge clk);
    if (reset) begin
      uph  = 0;
      nrun = 1'b0;
    end else begin
      nrun = (uph == 5) && (gcyc + 1 != suppress_at);
      ndout = dotv({samp[2], samp[1], samp[0]}, {samp[5], samp[4], samp[3]});
      uph  = (uph + 1) % 6;
    end
    gcyc++;
    #1;
    run  = nrun;
    dout = ndout;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic send(input logic [23:0] a, input logic [23:0] b, output int t);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    t = -1;
    for (int i = 0; i < 100 && t < 0; i++) begin
      tick();
      if (s_acc) t = s_cyc;
    end
    check("accept_within_bound", t >= 0, 1);
  endtask

  int         t1, t2, r0, nacc;
  logic [11:0] mask;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0;
    run = 1'b0; dout = '0; res_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // idle frames: req_ready only in phase 5
    mask = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      mask[i] = s_rr;
    end
    check("idle_ready_mask", mask, 12'h820);

    // single request
    got.delete();
    send(vec(1, 2, 3), vec(4, 5, 6), t1);
    idle(12);
    check("single_din_seq", {din_log[t1+1], din_log[t1+2], din_log[t1+3],
                             din_log[t1+4], din_log[t1+5], din_log[t1+6]}, 48'h010203040506);
    check("single_result", got_d(0), 32);
    check("single_latency", got_c(0) - t1, 8);

    // back-to-back
    got.delete();
    send(vec(7, 8, 9), vec(1, 2, 3), t1);
    send(vec(255, 255, 255), vec(255, 255, 255), t2);
    idle(20);
    check("b2b_accept_gap", t2 - t1, 6);
    check("b2b_no_din_gap", din_log[t2+1], 255);
    check("b2b_result0", got_d(0), 50);
    check("b2b_result1", got_d(1), 195075);
    check("b2b_result_spacing", got_c(1) - got_c(0), 6);

    // backpressure: two accepts, then a pop in phase 5 frees a slot
    res_ready = 1'b0;
    req_valid = 1'b1;
    req_a = 24'($urandom);
    req_b = 24'($urandom);
    nacc = 0;
    repeat (24) begin
      tick();
      if (s_acc) nacc++;
    end
    check("bp_accepts", nacc, 2);
    for (int i = 0; i < 6 && uph != 5; i++) tick();
    res_ready = 1'b1;
    tick();
    check("bp_pop_unblocks", s_acc, 1);
    idle(30);

    // randomized traffic
    repeat (400) begin
      req_valid = 1'($urandom_range(0, 1));
      req_a     = 24'($urandom);
      req_b     = 24'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    res_ready = 1'b1;
    idle(30);

    // unit withholds run for one frame
    got.delete();
    send(vec(3, 3, 3), vec(3, 3, 3), t1);
    suppress_at = t1 + 7;
    idle(20);
    suppress_at = -1;
    check("suppress_err_before", err_log[t1+7], 0);
    check("suppress_err_after", err_log[t1+8], 1);
    check("suppress_no_result", got.size(), 0);

    // stray run at phase 3
    do_reset();
    tick();
    check("err_cleared_by_reset", s_err, 0);
    for (int i = 0; i < 6 && uph != 3; i++) tick();
    run  = 1'b1;
    dout = '1;
    tick();
    tick();
    check("stray_run_err", s_err, 1);

    // reset while b0 is on din
    do_reset();
    send(vec(9, 9, 9), vec(9, 9, 9), t1);
    req_valid = 1'b0;
    for (int i = 0; i < 10 && gcyc < t1 + 4; i++) tick();
    reset = 1'b1;
    tick();
    check("b0_on_din", s_din, 9);
    reset = 1'b0;
    got.delete();
    tick();
    check("din_after_reset", s_din, 0);
    r0 = s_cyc;
    idle(20);
    check("aborted_no_result", got.size(), 0);
    send(vec(2, 3, 4), vec(5, 6, 7), t2);
    check("realigned_accept_phase", (t2 - r0) % 6, 5);
    idle(12);
    check("post_reset_result", got_d(0), 56);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected completion", gcyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
